// File: rtl/programmable_instruction_memory.sv
// programmable_instruction_memory: instruction memory with one-cycle registered fetch, fetch stall and a streaming program-load port
//   clk, reset                 : rising-edge clock, synchronous active-high reset
//   pc, fetch_en, stall        : fetch address, read request, hold current instruction/instr_valid
//   instruction, instr_valid   : registered fetched word and its valid flag
//   load_start, load_length    : begin a program load of load_length words (clamped to DEPTH)
//   load_data, load_valid      : streamed words, accepted when load_valid && load_ready
//   load_ready, load_busy      : high for the whole LOAD state
//   load_done                  : one-cycle pulse after the final word is written
module programmable_instruction_memory #(
    parameter int INSTR_WIDTH = 12,
    parameter int ADDR_WIDTH  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  pc,
    input  logic                   fetch_en,
    input  logic                   stall,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    input  logic                   load_start,
    input  logic [ADDR_WIDTH:0]    load_length,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   load_valid,
    output logic                   load_ready,
    output logic                   load_busy,
    output logic                   load_done
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {FETCH, LOAD} state_t;

    state_t                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic [ADDR_WIDTH-1:0]  wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]    rem_q, rem_d;
    logic [ADDR_WIDTH:0]    len;
    logic                   we;
    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

    // Clamping keeps a single load from wrapping onto addresses it already wrote.
    assign len = (load_length > DEPTH_L) ? DEPTH_L : load_length;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        wptr_d  = wptr_q;
        rem_d   = rem_q;
        we      = 1'b0;
        if (state_q == FETCH) begin
            if (load_start) begin
                valid_d = 1'b0;
                if (len == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d = LOAD;
                    wptr_d  = '0;
                    rem_d   = len;
                end
            end else if (!stall) begin
                instr_d = fetch_en ? mem_q[pc] : instr_q;
                valid_d = fetch_en;
            end
        end else begin
            valid_d = 1'b0;
            if (load_valid) begin
                we     = 1'b1;
                wptr_d = wptr_q + ADDR_WIDTH'(1);
                rem_d  = rem_q - (ADDR_WIDTH + 1)'(1);
                if (rem_q == (ADDR_WIDTH + 1)'(1)) begin
                    state_d = FETCH;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            instr_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            wptr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            wptr_q  <= wptr_d;
            rem_q   <= rem_d;
        end
    end

    // Memory contents survive reset; a write coinciding with reset is dropped as part of the abort.
    always_ff @(posedge clk) begin
        if (we && !reset) mem_q[wptr_q] <= load_data;
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign load_ready  = (state_q == LOAD);
    assign load_busy   = (state_q == LOAD);
    assign load_done   = done_q;
endmodule

// File: tb/tb_programmable_instruction_memory.sv
// tb_programmable_instruction_memory: self-checking bench for programmable_instruction_memory
module tb_programmable_instruction_memory;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  pc = '0;
    logic        fetch_en = 1'b0;
    logic        stall = 1'b0;
    logic [11:0] instruction;
    logic        instr_valid;
    logic        load_start = 1'b0;
    logic [3:0]  load_length = '0;
    logic [11:0] load_data = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic        load_busy;
    logic        load_done;

    int          checks = 0;
    int          failures = 0;
    logic [11:0] model [8];
    logic [11:0] exp_q [$];
    logic [11:0] words [8] = '{12'h035, 12'h0E7, 12'h4B3, 12'h3A7, 12'hA1D, 12'h157, 12'hA6F, 12'hEDB};

    programmable_instruction_memory #(.INSTR_WIDTH(12), .ADDR_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en), .stall(stall),
        .instruction(instruction), .instr_valid(instr_valid),
        .load_start(load_start), .load_length(load_length), .load_data(load_data),
        .load_valid(load_valid), .load_ready(load_ready), .load_busy(load_busy),
        .load_done(load_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (instruction !== 12'h000 || instr_valid !== 1'b0 || load_busy !== 1'b0 || load_ready !== 1'b0 || load_done !== 1'b0) begin
            failures++;
            $display("FAIL reset: instr=%h valid=%b busy=%b ready=%b done=%b, required 000 0 0 0 0", instruction, instr_valid, load_busy, load_ready, load_done);
        end
    endtask

    // Fetches every address in order; expected words come from the bench model via the scoreboard.
    task automatic test_readback(input string tag);
        logic [11:0] e;
        for (int i = 0; i < 8; i++) begin
            fetch_en = 1'b1;
            pc = 3'(i);
            exp_q.push_back(model[i]);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (instruction !== e || instr_valid !== 1'b1) begin
                failures++;
                $display("FAIL %s addr %0d: instr=%h valid=%b, required %h 1", tag, i, instruction, instr_valid, e);
            end
        end
        fetch_en = 1'b0;
        tick();
    endtask

    task automatic test_load;
        int ready_cycles = 0;
        int done_cycles = 0;
        load_start = 1'b1;
        load_length = 4'd8;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (load_ready === 1'b1) ready_cycles++;
            if (load_done === 1'b1) done_cycles++;
            load_valid = 1'b1;
            load_data = words[i];
            model[i] = words[i];
            tick();
        end
        load_valid = 1'b0;
        checks++;
        if (load_done !== 1'b1 || load_busy !== 1'b0) begin
            failures++;
            $display("FAIL load_end: done=%b busy=%b, required 1 0", load_done, load_busy);
        end
        tick();
        if (load_ready === 1'b1) ready_cycles++;
        if (load_done === 1'b1) done_cycles++;
        checks++;
        if (ready_cycles != 8 || done_cycles != 0 || load_busy !== 1'b0) begin
            failures++;
            $display("FAIL load_ready_count: ready_cycles=%0d extra_done=%0d busy=%b, required 8 0 0", ready_cycles, done_cycles, load_busy);
        end
    endtask

    task automatic test_fetch_drop;
        fetch_en = 1'b1;
        pc = 3'd6;
        exp_q.push_back(model[6]);
        tick();
        fetch_en = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || instruction !== exp_q[0]) begin
            failures++;
            $display("FAIL fetch_drop: instr=%h valid=%b, required %h 0", instruction, instr_valid, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_stall;
        logic [11:0] e;
        fetch_en = 1'b1;
        pc = 3'd2;
        exp_q.push_back(model[2]);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (instruction !== e || instruction !== 12'h4B3 || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_pre: instr=%h valid=%b, required 4b3 1", instruction, instr_valid);
        end
        pc = 3'd5;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (instruction !== 12'h4B3 || instr_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold %0d: instr=%h valid=%b, required 4b3 1", i, instruction, instr_valid);
            end
        end
        stall = 1'b0;
        exp_q.push_back(model[5]);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (instruction !== e || instruction !== 12'h157 || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: instr=%h valid=%b, required 157 1", instruction, instr_valid);
        end
        fetch_en = 1'b0;
        tick();
    endtask

    task automatic test_gapped;
        bit          v [6] = '{1, 0, 1, 0, 0, 1};
        logic [11:0] d [6] = '{12'h111, 12'hF0F, 12'h222, 12'hF1F, 12'hF2F, 12'h333};
        int          k = 0;
        load_start = 1'b1;
        load_length = 4'd3;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            load_valid = v[i];
            load_data = d[i];
            if (v[i]) begin
                model[k] = d[i];
                k++;
            end
            tick();
            if (i < 5) begin
                checks++;
                if (load_done !== 1'b0 || load_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL gapped_mid %0d: done=%b busy=%b, required 0 1", i, load_done, load_busy);
                end
            end
        end
        load_valid = 1'b0;
        checks++;
        if (load_done !== 1'b1 || load_busy !== 1'b0) begin
            failures++;
            $display("FAIL gapped_done: done=%b busy=%b, required 1 0", load_done, load_busy);
        end
        tick();
    endtask

    task automatic test_reset_midload;
        logic [11:0] two [2] = '{12'hAAA, 12'hBBB};
        load_start = 1'b1;
        load_length = 4'd8;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data = two[i];
            model[i] = two[i];
            tick();
        end
        load_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (load_busy !== 1'b0 || load_ready !== 1'b0 || load_done !== 1'b0 || instr_valid !== 1'b0 || instruction !== 12'h000) begin
            failures++;
            $display("FAIL reset_midload: busy=%b ready=%b done=%b valid=%b instr=%h, required 0 0 0 0 000", load_busy, load_ready, load_done, instr_valid, instruction);
        end
        tick();
        checks++;
        if (load_done !== 1'b0 || load_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_midload_after: done=%b busy=%b, required 0 0", load_done, load_busy);
        end
    endtask

    task automatic test_len0;
        load_start = 1'b1;
        load_length = 4'd0;
        tick();
        load_start = 1'b0;
        checks++;
        if (load_done !== 1'b1 || load_ready !== 1'b0) begin
            failures++;
            $display("FAIL len0_pulse: done=%b ready=%b, required 1 0", load_done, load_ready);
        end
        load_valid = 1'b1;
        load_data = 12'hDEA;
        tick();
        load_valid = 1'b0;
        checks++;
        if (load_done !== 1'b0 || load_ready !== 1'b0) begin
            failures++;
            $display("FAIL len0_after: done=%b ready=%b, required 0 0", load_done, load_ready);
        end
    endtask

    task automatic test_len15;
        int accepted = 0;
        load_start = 1'b1;
        load_length = 4'd15;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (load_ready === 1'b1) accepted++;
            load_valid = 1'b1;
            load_data = 12'h500 + 12'(i);
            if (i < 8) model[i] = 12'h500 + 12'(i);
            tick();
        end
        load_valid = 1'b0;
        checks++;
        if (accepted != 8 || load_busy !== 1'b0) begin
            failures++;
            $display("FAIL len15: accepted=%0d busy=%b, required 8 0", accepted, load_busy);
        end
    endtask

    task automatic test_start_with_fetch;
        logic [11:0] e;
        fetch_en = 1'b1;
        pc = 3'd1;
        exp_q.push_back(model[1]);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (instruction !== e || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL start_fetch_pre: instr=%h valid=%b, required %h 1", instruction, instr_valid, e);
        end
        load_start = 1'b1;
        load_length = 4'd1;
        pc = 3'd3;
        tick();
        load_start = 1'b0;
        checks++;
        if (load_busy !== 1'b1 || instr_valid !== 1'b0 || instruction !== e) begin
            failures++;
            $display("FAIL start_fetch: busy=%b valid=%b instr=%h, required 1 0 %h", load_busy, instr_valid, instruction, e);
        end
        load_valid = 1'b1;
        load_data = 12'h777;
        model[0] = 12'h777;
        tick();
        load_valid = 1'b0;
        checks++;
        if (load_done !== 1'b1 || load_busy !== 1'b0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL start_fetch_done: done=%b busy=%b valid=%b, required 1 0 0", load_done, load_busy, instr_valid);
        end
        fetch_en = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model[i] = '0;
        test_reset();
        test_load();
        test_readback("fetch");
        test_fetch_drop();
        test_stall();
        test_gapped();
        test_readback("gapped");
        test_reset_midload();
        test_readback("reset_midload");
        test_len0();
        test_readback("len0");
        test_len15();
        test_readback("len15");
        test_start_with_fetch();
        test_readback("start_fetch");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
